// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared 32-bit port.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface mem_port_arbiter_if;
    logic        req_a;
    logic        we_a;
    logic        req_b;
    logic        we_b;
    logic        ack_a;
    logic        ack_b;
    logic        err;
    logic [31:0] rdata;
    logic        sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req_a, we_a, req_b, we_b, mem_rdata, mem_ack,
        output ack_a, ack_b, err, rdata, sel, mem_req, mem_we
    );

    modport master (
        output req_a, we_a, req_b, we_b, mem_rdata, mem_ack,
        input  ack_a, ack_b, err, rdata, sel, mem_req, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the single memory port: grant, hold, ack, release,
// with a watchdog that ends a transfer with err if the memory never acknowledges.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;   // 1 = A owns the port
    logic          last_q, last_d;     // 1 = A was granted most recently
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          win_a;

    // On a tie the requester that was not served last wins.
    assign win_a = bus.req_a && (!bus.req_b || !last_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    state_d = BUSY;
                    owner_d = win_a;
                    last_d  = win_a;
                    we_d    = win_a ? bus.we_a : bus.we_b;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_d = DONE;
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Every output is decoded from registered state so requests never reach the port combinationally.
    assign bus.mem_req = (state_q == BUSY);
    assign bus.mem_we  = (state_q == BUSY) && we_q;
    assign bus.ack_a   = (state_q == DONE) && owner_q;
    assign bus.ack_b   = (state_q == DONE) && !owner_q;
    assign bus.err     = (state_q == DONE) && err_q;
    assign bus.rdata   = rdata_q;
    assign bus.sel     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs are driven and outputs sampled on the falling
// clock edge; every expected value is written out by hand from the intended behaviour.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT(4),
        .CW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic test_reset();
        rst = 1'b1;
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.req_b = 1'b0; bus.we_b = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we got=%0b exp=0", bus.mem_we); end
        checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack_a got=%0b exp=0", bus.ack_a); end
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack_b got=%0b exp=0", bus.ack_b); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", bus.err); end
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("[TB] FAIL reset_sel got=%0b exp=1", bus.sel); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=00000000", bus.rdata); end
        rst = 1'b0;
    endtask

    task automatic test_single_read_a();
        @(negedge clk);
        bus.req_a = 1'b1; bus.we_a = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rdA_busy1_mem_req got=%0b exp=1", bus.mem_req); end
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("[TB] FAIL rdA_busy1_sel got=%0b exp=1", bus.sel); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rdA_busy1_mem_we got=%0b exp=0", bus.mem_we); end
        checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL rdA_busy1_ack_a got=%0b exp=0", bus.ack_a); end
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL rdA_busy1_ack_b got=%0b exp=0", bus.ack_b); end
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rdA_busy2_mem_req got=%0b exp=1", bus.mem_req); end
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("[TB] FAIL rdA_busy2_sel got=%0b exp=1", bus.sel); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (bus.ack_a !== 1'b1) begin failures++; $display("[TB] FAIL rdA_done_ack_a got=%0b exp=1", bus.ack_a); end
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL rdA_done_ack_b got=%0b exp=0", bus.ack_b); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL rdA_done_err got=%0b exp=0", bus.err); end
        checks++; if (bus.rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rdA_done_rdata got=%h exp=deadbeef", bus.rdata); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rdA_done_mem_req got=%0b exp=0", bus.mem_req); end
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("[TB] FAIL rdA_done_sel got=%0b exp=1", bus.sel); end
        bus.req_a = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL rdA_idle_ack_a got=%0b exp=0", bus.ack_a); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rdA_idle_mem_req got=%0b exp=0", bus.mem_req); end
    endtask

    task automatic test_tie();
        logic        exp_a;
        logic [31:0] exp_rd;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_a = 1'b1; bus.req_b = 1'b1; bus.we_a = 1'b0; bus.we_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a  = (i % 2 == 0);
            exp_rd = 32'h1000_0000 + 32'(i);
            @(negedge clk);
            checks++; if (bus.sel !== exp_a) begin failures++; $display("[TB] FAIL tie%0d_busy_sel got=%0b exp=%0b", i, bus.sel, exp_a); end
            checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL tie%0d_busy_mem_req got=%0b exp=1", i, bus.mem_req); end
            bus.mem_ack = 1'b1; bus.mem_rdata = exp_rd;
            @(negedge clk);
            checks++; if (bus.ack_a !== exp_a) begin failures++; $display("[TB] FAIL tie%0d_ack_a got=%0b exp=%0b", i, bus.ack_a, exp_a); end
            checks++; if (bus.ack_b !== !exp_a) begin failures++; $display("[TB] FAIL tie%0d_ack_b got=%0b exp=%0b", i, bus.ack_b, !exp_a); end
            checks++; if (bus.rdata !== exp_rd) begin failures++; $display("[TB] FAIL tie%0d_rdata got=%h exp=%h", i, bus.rdata, exp_rd); end
            checks++; if (bus.sel !== exp_a) begin failures++; $display("[TB] FAIL tie%0d_done_sel got=%0b exp=%0b", i, bus.sel, exp_a); end
            bus.mem_ack = 1'b0;
            if (i == 3) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
            @(negedge clk);
            checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL tie%0d_idle_mem_req got=%0b exp=0", i, bus.mem_req); end
            checks++; if (bus.sel !== exp_a) begin failures++; $display("[TB] FAIL tie%0d_idle_sel got=%0b exp=%0b", i, bus.sel, exp_a); end
        end
    endtask

    task automatic test_write_b();
        bus.req_b = 1'b1; bus.we_b = 1'b1;
        @(negedge clk);
        checks++; if (bus.sel !== 1'b0) begin failures++; $display("[TB] FAIL wrB_busy_sel got=%0b exp=0", bus.sel); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL wrB_busy_mem_we got=%0b exp=1", bus.mem_we); end
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL wrB_busy_mem_req got=%0b exp=1", bus.mem_req); end
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL wrB_busy_ack_b got=%0b exp=0", bus.ack_b); end
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL wrB_busy2_mem_req got=%0b exp=1", bus.mem_req); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.ack_b !== 1'b1) begin failures++; $display("[TB] FAIL wrB_done_ack_b got=%0b exp=1", bus.ack_b); end
        checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL wrB_done_ack_a got=%0b exp=0", bus.ack_a); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL wrB_done_err got=%0b exp=0", bus.err); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL wrB_done_mem_req got=%0b exp=0", bus.mem_req); end
        checks++; if (bus.rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL wrB_done_rdata got=%h exp=12345678", bus.rdata); end
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL wrB_idle_ack_b got=%0b exp=0", bus.ack_b); end
    endtask

    task automatic test_stray_ack();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL stray%0d_ack got=%0b%0b exp=00", c, bus.ack_a, bus.ack_b); end
            checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL stray%0d_mem_req got=%0b exp=0", c, bus.mem_req); end
            checks++; if (bus.rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL stray%0d_rdata got=%h exp=12345678", c, bus.rdata); end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL to_busy%0d_mem_req got=%0b exp=1", c, bus.mem_req); end
            checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL to_busy%0d_ack_a got=%0b exp=0", c, bus.ack_a); end
        end
        @(negedge clk);
        checks++; if (bus.ack_a !== 1'b1) begin failures++; $display("[TB] FAIL to_done_ack_a got=%0b exp=1", bus.ack_a); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("[TB] FAIL to_done_err got=%0b exp=1", bus.err); end
        checks++; if (bus.rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL to_done_rdata got=%h exp=12345678", bus.rdata); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL to_done_mem_req got=%0b exp=0", bus.mem_req); end
        bus.req_a = 1'b0;
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL to_idle_err got=%0b exp=0", bus.err); end
        bus.req_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL tolast_busy%0d_mem_req got=%0b exp=1", c, bus.mem_req); end
            if (c == 3) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D; end
        end
        @(negedge clk);
        checks++; if (bus.ack_a !== 1'b1) begin failures++; $display("[TB] FAIL tolast_done_ack_a got=%0b exp=1", bus.ack_a); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL tolast_done_err got=%0b exp=0", bus.err); end
        checks++; if (bus.rdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL tolast_done_rdata got=%h exp=cafef00d", bus.rdata); end
        bus.req_a = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        bus.req_b = 1'b1; bus.we_b = 1'b0;
        @(negedge clk);
        checks++; if (bus.sel !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy_sel got=%0b exp=0", bus.sel); end
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_mem_req got=%0b exp=1", bus.mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async_mem_req got=%0b exp=0", bus.mem_req); end
        checks++; if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async_ack got=%0b%0b exp=00", bus.ack_a, bus.ack_b); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async_err got=%0b exp=0", bus.err); end
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_async_sel got=%0b exp=1", bus.sel); end
        @(negedge clk);
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_held_ack_b got=%0b exp=0", bus.ack_b); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.sel !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_regrant_sel got=%0b exp=0", bus.sel); end
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_regrant_mem_req got=%0b exp=1", bus.mem_req); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack_b !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_done_ack_b got=%0b exp=1", bus.ack_b); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done_err got=%0b exp=0", bus.err); end
        bus.req_b = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ownership();
        bus.req_b = 1'b1; bus.we_b = 1'b1; bus.req_a = 1'b0; bus.we_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.sel !== 1'b0) begin failures++; $display("[TB] FAIL own_busy%0d_sel got=%0b exp=0", c, bus.sel); end
            checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL own_busy%0d_mem_we got=%0b exp=1", c, bus.mem_we); end
            checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL own_busy%0d_ack_a got=%0b exp=0", c, bus.ack_a); end
            bus.req_a = ~bus.req_a; bus.we_a = ~bus.we_a;
            if (c == 2) bus.mem_ack = 1'b1;
        end
        @(negedge clk);
        checks++; if (bus.ack_b !== 1'b1) begin failures++; $display("[TB] FAIL own_done_ack_b got=%0b exp=1", bus.ack_b); end
        checks++; if (bus.ack_a !== 1'b0) begin failures++; $display("[TB] FAIL own_done_ack_a got=%0b exp=0", bus.ack_a); end
        checks++; if (bus.sel !== 1'b0) begin failures++; $display("[TB] FAIL own_done_sel got=%0b exp=0", bus.sel); end
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.req_b = 1'b0; bus.we_b = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL own_idle_mem_req got=%0b exp=0", bus.mem_req); end
        @(negedge clk);
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("[TB] FAIL own_grantA_sel got=%0b exp=1", bus.sel); end
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL own_grantA_mem_req got=%0b exp=1", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL own_grantA_mem_we got=%0b exp=0", bus.mem_we); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack_a !== 1'b1) begin failures++; $display("[TB] FAIL own_doneA_ack_a got=%0b exp=1", bus.ack_a); end
        checks++; if (bus.ack_b !== 1'b0) begin failures++; $display("[TB] FAIL own_doneA_ack_b got=%0b exp=0", bus.ack_b); end
        bus.req_a = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read_a();
        test_tie();
        test_write_b();
        test_stray_ack();
        test_timeout();
        test_reset_mid_busy();
        test_ownership();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory/bus port of the multicycle CPU system between two requesters: A (CPU) and B (peripheral/DMA master).
- Owns the `sel` line of the 32-bit 2:1 address/write-data muxes in front of the port.
  - `sel=1` routes A.
  - `sel=0` routes B.
- Sequences each transfer: grant, hold, acknowledge, release.
- Round-robin fairness on contention; watchdog timeout if the memory never acknowledges.

Parameters:
- TIMEOUT, 255, cycles in BUSY without `mem_ack` before the transfer is aborted with error (1..65535).
- CW, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_a  in  1  A transfer request; level, held until ack_a.
- we_a  in  1  A write enable; stable while req_a is high.
- req_b  in  1  B transfer request; level, held until ack_b.
- we_b  in  1  B write enable; stable while req_b is high.
- ack_a  out  1  one-cycle completion pulse to A.
- ack_b  out  1  one-cycle completion pulse to B.
- err  out  1  valid with an ack pulse; 1 means the transfer timed out.
- rdata  out  32  captured read data; valid with an ack pulse, held until the next capture.
- sel  out  1  mux select to the address/wdata 2:1 muxes: 1 means A, 0 means B.
- mem_req  out  1  request to the memory port.
- mem_we  out  1  write enable to the memory port (the owner's we).
- mem_rdata  in  32  memory read data.
- mem_ack  in  1  memory completion, sampled while mem_req is high.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, owner=A, last=B (so A wins the first tie), counter=0.
  - All outputs 0, except sel=1 (points at A) and rdata=0.
- States: IDLE, BUSY, DONE. All outputs are registered or decoded from registered state; there are no combinational req-to-mem paths.
- IDLE:
  - Samples req_a/req_b at the clock edge.
  - Only one request high: grant it.
  - Both high: grant the requester that is not `last`.
  - On grant: owner := winner, last := winner, sel := (winner==A), counter := 0, go to BUSY.
  - No request: stay; sel keeps its previous value.
- BUSY:
  - mem_req=1; mem_we = owner's we.
  - sel is stable for the whole transfer; the requests of the non-owner are ignored.
  - Edge with mem_ack=1: rdata := mem_rdata, err := 0, go to DONE.
  - Else if counter==TIMEOUT-1: err := 1, rdata unchanged, go to DONE.
  - Else counter := counter+1.
- DONE (one cycle):
  - mem_req=0.
  - The owner's ack=1 with err valid; the other ack=0. Then go to IDLE.
  - ack/err are 0 in every state except DONE.
- Latency:
  - The request edge in IDLE is followed by mem_req in the next cycle.
  - A mem_ack edge is followed by ack in the next cycle.
  - Minimum transfer length is 3 cycles, from IDLE grant to ack. This includes one mandatory bus turnaround cycle (DONE) between owners.
- Requester contract:
  - Deassert req at the clock edge that ends the ack cycle.
  - A req still high in the following IDLE is treated as a new request.
- Boundaries:
  - mem_ack arriving in the same edge as the timeout: mem_ack wins, err=0.
  - mem_ack while not BUSY: ignored.
  - Requests changing mid-BUSY: no effect on owner or sel.
  - Async rst mid-BUSY: mem_req drops immediately and no ack is issued. The requester must reissue the request.
  - Back-to-back A requests while B also waits: B is granted next (round-robin), so neither requester starves.

Test Plan:
- Single read A: req_a=1, we_a=0, mem_ack after 2 BUSY cycles with mem_rdata=32'hDEADBEEF -> sel=1 throughout, mem_we=0, ack_a pulse with rdata=32'hDEADBEEF, err=0, ack_b never high.
- Tie after reset: req_a and req_b rise together, each transfer acked after 1 cycle, both reqs reasserted immediately -> grant order A, B, A, B. sel toggles 1,0,1,0 and only changes in IDLE.
- Write B: req_b=1, we_b=1 -> sel=0, mem_we=1, mem_req high until mem_ack, ack_b pulse one cycle later, err=0.
- Timeout: TIMEOUT=4, req_a with mem_ack never asserted -> exactly 4 BUSY cycles, then ack_a=1, err=1, rdata unchanged, mem_req=0. Repeat with mem_ack on the 4th cycle -> err=0.
- Reset mid-operation: assert rst asynchronously between clock edges during BUSY -> mem_req, ack_*, err go 0 without waiting for an edge, sel=1. After release, req_b pending is granted with sel=0.
- Ownership stability: during a B transfer toggle req_a every cycle -> sel stays 0, mem_we follows we_b only, and A is granted in the IDLE after ack_b.
